// File: rtl/pixel_pack_pkg.sv
// Shared constants and helpers for the 64-bit pixel packing and unpacking blocks.
package pixel_pack_pkg;

    localparam int WORD_LOGBITS = 6;
    localparam int WORD_BITS    = 64;

    // Widest lane-count field, reached with 8-bit pixels (counts 1..8).
    localparam int LANE_CNT_W   = WORD_LOGBITS - 3 + 1;

    function automatic int lanes(input int inlogbits);
        return 1 << (WORD_LOGBITS - inlogbits);
    endfunction

    function automatic int lane_cnt_w(input int inlogbits);
        return WORD_LOGBITS - inlogbits + 1;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// One-entry valid/ready output register: loads when empty or draining, holds while stalled.
// Zero-cycle input-to-ready path; o_can_load depends only on state and i_rdy.
module pack_out_reg #(
    parameter int W = 64
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    input  logic         i_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic         o_can_load
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    assign o_can_load = !r_vld || i_rdy;
    assign o_vld      = r_vld;
    assign o_dat      = r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (o_can_load) begin
            r_vld <= i_load;
            if (i_load) begin
                r_dat <= i_dat;
            end
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs 8/16/32-bit pixels into 64-bit words, lane 0 at LSBs; word valid the cycle after its final pixel.
// Optional PIXEL_WORD_PACKER_FLUSH_EN adds in_last/out_last/out_lanes for zero-padded partial words.
module pixel_word_packer
    import pixel_pack_pkg::*;
#(
    parameter int INLOGBITS  = 3,
    parameter int OUTLOGBITS = WORD_LOGBITS
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(1<<INLOGBITS)-1:0]     in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
    input  logic                          in_last,
    output logic                          out_last,
    output logic [OUTLOGBITS-INLOGBITS:0] out_lanes,
`endif
    output logic [WORD_BITS-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int PW = 1 << INLOGBITS;
    localparam int N  = lanes(INLOGBITS);
    localparam int CW = OUTLOGBITS - INLOGBITS;

    logic [CW-1:0]         r_cnt;
    logic [N-2:0][PW-1:0]  r_acc;

    logic                  w_hs;
    logic                  w_full_lane;
    logic                  w_last;
    logic                  w_close;
    logic                  w_can_load;
    logic [WORD_BITS-1:0]  w_word;

    assign w_full_lane = (r_cnt == CW'(N - 1));
    assign w_hs        = in_valid && in_ready;
    assign w_close     = w_hs && (w_full_lane || w_last);

`ifdef PIXEL_WORD_PACKER_FLUSH_EN
    assign w_last   = in_last;
    // Conservative so that in_ready never depends on in_last.
    assign in_ready = w_can_load;
`else
    assign w_last   = 1'b0;
    assign in_ready = !w_full_lane || w_can_load;
`endif

    // Lanes above the current one are masked so a flushed word is zero-padded.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (i < int'(r_cnt)) begin
                w_word[i*PW +: PW] = r_acc[i];
            end
        end
        w_word[int'(r_cnt)*PW +: PW] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_hs) begin
            if (w_close) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                for (int i = 0; i < N - 1; i++) begin
                    if (int'(r_cnt) == i) begin
                        r_acc[i] <= in_data;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef PIXEL_WORD_PACKER_FLUSH_EN
    localparam int LW = CW + 1;
    localparam int OW = WORD_BITS + 1 + LW;
    logic [LW-1:0] w_lanes;
    assign w_lanes = {1'b0, r_cnt} + 1'b1;
`else
    localparam int OW = WORD_BITS;
`endif

    logic [OW-1:0] w_pay;
    logic [OW-1:0] w_out_pay;

`ifdef PIXEL_WORD_PACKER_FLUSH_EN
    assign w_pay     = {w_lanes, w_last, w_word};
    assign out_lanes = w_out_pay[OW-1 -: LW];
    assign out_last  = w_out_pay[WORD_BITS];
`else
    assign w_pay     = w_word;
`endif
    assign out_data  = w_out_pay[WORD_BITS-1:0];

    pack_out_reg #(
        .W (OW)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_close),
        .i_dat      (w_pay),
        .i_rdy      (out_ready),
        .o_vld      (out_valid),
        .o_dat      (w_out_pay),
        .o_can_load (w_can_load)
    );

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop and compare.
module tb_pixel_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  a_in_data;
    logic        a_in_valid, a_in_ready, a_in_last;
    logic [63:0] a_out_data;
    logic        a_out_valid, a_out_ready;
    logic [15:0] b_in_data;
    logic        b_in_valid, b_in_ready;
    logic [63:0] b_out_data;
    logic        b_out_valid, b_out_ready;
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
    logic        a_out_last, b_in_last, b_out_last;
    logic [3:0]  a_out_lanes;
    logic [2:0]  b_out_lanes;
`endif

    pixel_word_packer #(.INLOGBITS(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
        .in_last   (a_in_last),
        .out_last  (a_out_last),
        .out_lanes (a_out_lanes),
`endif
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    pixel_word_packer #(.INLOGBITS(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
        .in_last   (b_in_last),
        .out_last  (b_out_last),
        .out_lanes (b_out_lanes),
`endif
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected A entries: {last, lanes[3:0], data[63:0]}.
    logic [68:0] exp_a[$];
    logic [63:0] exp_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor A: scoreboard pop plus hold-while-stalled check.
    logic        a_prev_stall = 1'b0;
    logic [63:0] a_prev_data;
    logic [68:0] a_e;
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                chk("a_hold_valid", a_out_valid, 64'd1);
                chk("a_hold_data", a_out_data, a_prev_data);
            end
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got word %h expected no word", a_out_data);
                end else begin
                    a_e = exp_a.pop_front();
                    chk("a_data", a_out_data, a_e[63:0]);
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
                    chk("a_lanes", a_out_lanes, a_e[67:64]);
                    chk("a_last", a_out_last, a_e[68]);
`endif
                end
            end
            a_prev_stall = a_out_valid && !a_out_ready;
            a_prev_data  = a_out_data;
        end
    end

    // Monitor B: scoreboard pop plus word count and timing span.
    int     b_words = 0;
    longint b_first = 0, b_last = 0;
    logic [63:0] b_e;
    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (b_words == 0) b_first = cyc;
            b_last = cyc;
            b_words++;
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got word %h expected no word", b_out_data);
            end else begin
                b_e = exp_b.pop_front();
                chk("b_data", b_out_data, b_e);
            end
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            a_out_ready = ($urandom_range(0, 1) != 0);
        end
    end

    task automatic send_a(input logic [7:0] p, input logic last);
        int   budget;
        logic ok;
        a_in_data  = p;
        a_in_valid = 1'b1;
        a_in_last  = last;
        budget = 0;
        do begin
            @(negedge clk); ok = a_in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!ok && budget < 200);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL a_send_timeout: in_ready 0 expected 1 within 200 cycles");
        end
        a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] p);
        int   budget;
        logic ok;
        b_in_data  = p;
        b_in_valid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk); ok = b_in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!ok && budget < 200);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL b_send_timeout: in_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain(input string name);
        int budget = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || a_out_valid || b_out_valid) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) begin
            checks++; errors++;
            $display("FAIL %s_drain: pending a=%0d b=%0d expected 0 0", name, exp_a.size(), exp_b.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pb(input int i);
        logic [7:0] v;
        v = i[7:0];
        return {v, v ^ 8'hC3};
    endfunction

    logic [63:0] mw;
    int          mc;
    logic [7:0]  rp;

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
        b_in_last = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_a_valid", a_out_valid, 64'd0);
        chk("rst_a_data", a_out_data, 64'd0);
        chk("rst_a_ready", a_in_ready, 64'd1);
        chk("rst_b_valid", b_out_valid, 64'd0);
        chk("rst_b_ready", b_in_ready, 64'd1);
`ifdef PIXEL_WORD_PACKER_FLUSH_EN
        chk("rst_a_lanes", a_out_lanes, 64'd0);
        chk("rst_a_last", a_out_last, 64'd0);
`endif
        @(posedge clk); #1;

        // One full word back-to-back, valid for exactly one cycle.
        a_out_ready = 1'b1;
        exp_a.push_back({1'b0, 4'd8, 64'h0807060504030201});
        for (int i = 1; i <= 8; i++) send_a(8'(i), 1'b0);
        a_in_valid = 1'b0;
        @(negedge clk); chk("t1_valid_next_cycle", a_out_valid, 64'd1);
        @(negedge clk); chk("t1_valid_one_cycle", a_out_valid, 64'd0);
        drain("t1");

`ifndef PIXEL_WORD_PACKER_FLUSH_EN
        // Output stalled: 15 pixels accepted, 16th blocked, first word held.
        a_out_ready = 1'b0;
        exp_a.push_back({1'b0, 4'd8, 64'h0807060504030201});
        exp_a.push_back({1'b0, 4'd8, 64'h100F0E0D0C0B0A09});
        for (int i = 1; i <= 15; i++) send_a(8'(i), 1'b0);
        a_in_data  = 8'h10;
        a_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_in_ready_low", a_in_ready, 64'd0);
            chk("t2_word_held", a_out_data, 64'h0807060504030201);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        send_a(8'h10, 1'b0);
        a_in_valid = 1'b0;
        drain("t2");
`else
        // Flush a 3-lane partial word, then a full word.
        a_out_ready = 1'b1;
        exp_a.push_back({1'b1, 4'd3, 64'h0000000000CCBBAA});
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b0);
        send_a(8'hCC, 1'b1);
        exp_a.push_back({1'b0, 4'd8, 64'h2827262524232221});
        for (int i = 0; i < 8; i++) send_a(8'h21 + 8'(i), 1'b0);
        a_in_valid = 1'b0;
        drain("t3");
`endif

        // Reset mid-word discards the partial accumulator.
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_a(8'h50 + 8'(i), 1'b0);
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_rst", a_in_ready, 64'd1);
        chk("t4_valid_after_rst", a_out_valid, 64'd0);
        @(posedge clk); #1;
        exp_a.push_back({1'b0, 4'd8, 64'h1716151413121110});
        for (int i = 0; i < 8; i++) send_a(8'h10 + 8'(i), 1'b0);
        a_in_valid = 1'b0;
        drain("t4");

        // 16-bit pixels at full throughput.
        b_out_ready = 1'b1;
        for (int k = 0; k < 16; k++)
            exp_b.push_back({pb(4*k+3), pb(4*k+2), pb(4*k+1), pb(4*k)});
        for (int i = 0; i < 64; i++) send_b(pb(i));
        b_in_valid = 1'b0;
        drain("t5");
        chk("t5_word_count", 64'(b_words), 64'd16);
        chk("t5_word_span", 64'(b_last - b_first), 64'd60);

        // Random valid/ready over 10k pixels against a packing model.
        mw = '0; mc = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            rp = 8'($urandom);
            mw[mc*8 +: 8] = rp;
            mc++;
            if (mc == 8) begin
                exp_a.push_back({1'b0, 4'd8, mw});
                mc = 0;
                mw = '0;
            end
            send_a(rp, 1'b0);
        end
        a_in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        a_out_ready = 1'b1;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Packs a stream of narrow pixels (8/16/32 bits) into 64-bit words for the host-facing output of an app wrapper. It is the inverse of the 64-bit-to-pixel unpacking done on the input side. It sits between a pixel-rate kernel's valid/ready output and the 64-bit `dout`/`dout_valid`/`dout_ready` port. Pixel k of a word occupies lane k, with lane 0 at the LSBs, so the first pixel lands in bits [7:0] for 8-bit pixels. It sustains one pixel per cycle under full throughput.

## Interface
- `INLOGBITS`, default 3: log2 of pixel width; PW = 1<<INLOGBITS; legal 3..5.
- `OUTLOGBITS`, default 6: log2 of word width; fixed at 6 (64 bits); N = 1<<(OUTLOGBITS-INLOGBITS) lanes.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  PW  pixel.
- `in_valid`  in  1  pixel present.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `in_last`  in  1  flush marker on this pixel (`PIXEL_WORD_PACKER_FLUSH_EN` only).
- `out_data`  out  64  packed word.
- `out_valid`  out  1  word present.
- `out_ready`  in  1  word taken when `out_valid && out_ready`.
- `out_last`  out  1  word closed by flush (`PIXEL_WORD_PACKER_FLUSH_EN` only).
- `out_lanes`  out  OUTLOGBITS-INLOGBITS+1  count of valid lanes, 1..N (`PIXEL_WORD_PACKER_FLUSH_EN` only).

## Operation
- State:
  - lane counter `cnt` (0..N-1).
  - accumulator holding lanes 0..N-2.
  - one-entry output register holding `out_data`, `out_valid`, `out_last`, `out_lanes`.
- Pixel accepted with `cnt < N-1` (and not last): write it to lane `cnt` of the accumulator; `cnt++`.
- Pixel accepted with `cnt == N-1`:
  - Output register loads {pixel, accumulator lanes N-2..0}.
  - `out_lanes` = N, `out_last` = 0.
  - `cnt` returns to 0.
- Pixel accepted with `in_last = 1` (flush build):
  - Output register loads the accumulator plus this pixel at lane `cnt`.
  - Lanes above `cnt` are forced to 0.
  - `out_lanes` = `cnt`+1, `out_last` = 1.
  - `cnt` returns to 0.
- Accumulator lanes are cleared when their word is loaded, so stale data never leaks into a partial word.
- Output register state:
  - Loads only when empty or being drained in the same cycle.
  - Otherwise `out_data`, `out_last` and `out_lanes` are held stable while `out_valid && !out_ready`.
- `in_ready` without the flush feature: `(cnt != N-1) || !out_valid || out_ready`.
  - Lanes 0..N-2 are always accepted, even while the output stalls.
- `in_ready` with the flush feature: `!out_valid || out_ready`.
  - This is conservative, so that `in_ready` never depends on `in_last`.
- Neither `in_ready` nor `out_valid` depends combinationally on `in_valid`.

## Timing
- Reset values: `cnt` = 0, accumulator = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_lanes` = 0.
- `in_ready` is 1 on the first cycle after reset.
- Latency: a word is on `out_data` with `out_valid` = 1 in the cycle after the handshake of its final (or last-flagged) pixel.
- Throughput: with `in_valid` and `out_ready` held at 1, one pixel per cycle, one word every N cycles, no bubbles.
- Simultaneous drain and load in one cycle: the output register takes the new word, and `out_valid` stays 1.
- `out_ready` = 1 while `out_valid` = 0 has no effect.
- Reset mid-word: the partial accumulator and any pending output word are discarded. No partial word is emitted.

## Configuration
- Macro: `PIXEL_WORD_PACKER_FLUSH_EN`.
- Defined:
  - `in_last`, `out_last` and `out_lanes` exist.
  - Partial words are emitted zero-padded.
  - `in_ready` follows the conservative rule in Operation.
- Undefined:
  - Those three ports are absent.
  - Words are emitted only when all N lanes are filled.
  - `in_ready` follows the lane-aware rule in Operation.

## Structure
- Package `pixel_pack_pkg`:
  - `WORD_LOGBITS` = 6 and `WORD_BITS` = 64.
  - Lane-count function `lanes(inlogbits)`.
  - Lane-count width constant.
  - Shared with the unpacking block.
- Sub-module `pack_out_reg`: the one-entry valid/ready output register (load, hold, drain) with a data width parameter. The packer instantiates it once.

## Test plan
- INLOGBITS=3, pixels 0x01..0x08 back-to-back, `out_ready` = 1 -> `out_data` = 0x0807060504030201, `out_valid` high for exactly 1 cycle, in the cycle after the 8th handshake.
- INLOGBITS=3, no flush, 16 pixels offered, `out_ready` = 0 -> 15 pixels accepted, `in_ready` low with `cnt` = 7, first word held stable. Raising `out_ready` -> words 0x..01 and 0x..09 emitted in order.
- Flush build, INLOGBITS=3, pixels 0xAA, 0xBB, 0xCC with `in_last` on 0xCC -> `out_data` = 0x0000000000CCBBAA, `out_lanes` = 3, `out_last` = 1. Next 8 pixels form a full word with `out_last` = 0.
- 5 pixels, then `rst` for 1 cycle, then pixels 0x10..0x17 -> single word 0x1716151413121110; nothing from the first 5 pixels.
- INLOGBITS=4, 64 pixels with `in_valid` and `out_ready` continuously 1 -> 16 words, one every 4 cycles, each word = {p3, p2, p1, p0} as 16-bit lanes.
- Random `in_valid`/`out_ready` toggling over 10k pixels -> output equals the scoreboard packing, and `out_data` never changes while stalled.
